// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one multi-cycle ALU between two requesters.
// One op in flight; operands held on the ALU until alu_ready, result returned on rspN.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/ready/op1/op2/code   request channel N (N=0 execute, N=1 addr/branch)
//   rspN_valid/ready                response channel N
//   rsp_result, rsp_err             result shared by both response channels
//   alu_op1/op2/code                operands and code to the ALU
//   alu_result, alu_ready           ALU completion
//
// Optional feature: define ALU_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT
// cycles; on expiry the op completes with rsp_result=0, rsp_err=1.

module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [2:0]       req0_code,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [2:0]       req1_code,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_code,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ready
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [2:0]       code_q, code_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             g0, g1;
  logic             rsp_take;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Tie goes to the requester that was not granted last.
  always_comb begin
    g0 = req0_valid & (~req1_valid | last_grant_q);
    g1 = req1_valid & ~g0;
  end

  always_comb begin
    rsp_take = gnt_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    code_d       = code_q;
    res_d        = res_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (g0 | g1) begin
          req0_ready   = g0;
          req1_ready   = g1;
          gnt_d        = g1;
          last_grant_d = g1;
          op1_d        = g1 ? req1_op1 : req0_op1;
          op2_d        = g1 ? req1_op2 : req0_op2;
          code_d       = g1 ? req1_code : req0_code;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // alu_ready may still reflect the previous op here.
        state_d = S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (alu_ready) begin
          res_d   = alu_result;
          state_d = S_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_take) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      code_q       <= 3'h0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      code_q       <= code_d;
      res_q        <= res_d;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp0_valid = (state_q == S_RESP) & ~gnt_q;
  assign rsp1_valid = (state_q == S_RESP) &  gnt_q;
  assign rsp_result = res_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_code   = ((state_q == S_ISSUE) | (state_q == S_WAIT)) ? code_q : 3'h0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter.
// Bench-side ALU stand-in plus a round-robin/result reference model.

module tb_alu_arbiter;

  localparam int W   = 32;
  localparam int TMO = 16;
  localparam logic [W-1:0] STALE = 32'hDEAD_BEEF;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_op1, req0_op2;
  logic [2:0]   req0_code;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_op1, req1_op2;
  logic [2:0]   req1_code;
  logic         rsp0_valid, rsp0_ready;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_err;
  logic [W-1:0] alu_op1, alu_op2;
  logic [2:0]   alu_code;
  logic [W-1:0] alu_result;
  logic         alu_ready;

  int total;
  int bad;

  alu_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_code(req0_code),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_code(req1_code),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_code(alu_code),
    .alu_result(alu_result), .alu_ready(alu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in. mode 0: ready after random latency in WAIT,
  // 1: never ready, 2: always ready, 3: ready only on the last timeout cycle.
  // The result reads STALE until the op has been on the bus for 2 cycles.
  int alu_mode;
  int age;
  int alu_lat;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, b,
                                          input logic [2:0] c);
    return (c == 3'h1) ? a + b : a ^ b;
  endfunction

  always @(negedge clk) begin
    if (alu_code != 3'h0) begin
      age = age + 1;
      if (age == 1) alu_lat = $urandom_range(0, 3);
    end else begin
      age = 0;
    end
    case (alu_mode)
      0:       alu_ready = (age >= 2 + alu_lat);
      1:       alu_ready = 1'b0;
      3:       alu_ready = (age == TMO + 1);
      default: alu_ready = 1'b1;
    endcase
    alu_result = (age >= 2) ? alu_fn(alu_op1, alu_op2, alu_code) : STALE;
  end

  // Reference model: expected result of an op and round-robin preference.
  int pref;

  function automatic logic [W-1:0] exp_res(input logic [W-1:0] a, b,
                                           input logic [2:0] c);
    if (c == 3'h0) return STALE;
    if (c == 3'h1) return a + b;
    return a ^ b;
  endfunction

  function automatic int exp_who(input bit v0, input bit v1);
    if (v0 && v1) return pref;
    return v0 ? 0 : 1;
  endfunction

  // Observations of one transaction.
  int           o_who;
  int           o_lat;
  logic [W-1:0] o_res;
  logic         o_err;
  logic [2:0]   o_code_iss;
  logic [2:0]   o_code_resp;
  bit           o_code_ok;
  bit           o_ok_hold;
  bit           o_wrong_ch;
  bit           o_dropped;
  bit           o_tmo;

  task automatic set_req(input int n, input logic [W-1:0] a, b,
                         input logic [2:0] c);
    if (n == 0) begin
      req0_op1 = a; req0_op2 = b; req0_code = c; req0_valid = 1'b1;
    end else begin
      req1_op1 = a; req1_op2 = b; req1_code = c; req1_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    alu_mode = 0;
    pref = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Waits for an accept pulse, then drops that requester's valid in ISSUE.
  task automatic wait_accept(output int who, output bit tmo);
    who = -1;
    tmo = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req0_ready === 1'b1) begin who = 0; break; end
      if (req1_ready === 1'b1) begin who = 1; break; end
      @(negedge clk);
    end
    if (who < 0) begin
      tmo = 1'b1;
      return;
    end
    @(negedge clk);
    #1;
    if (who == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic observe(input int hold);
    bit seen;
    o_lat = 0; o_res = '0; o_err = 1'b0;
    o_ok_hold = 1'b1; o_wrong_ch = 1'b0; o_dropped = 1'b0;
    o_code_ok = 1'b1; o_code_resp = 3'h0;
    wait_accept(o_who, o_tmo);
    if (o_tmo) return;
    o_code_iss = alu_code;
    seen = 1'b0;
    for (int i = 2; i <= 200; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid) begin
        seen = 1'b1;
        o_lat = i;
        break;
      end
      if (alu_code !== o_code_iss) o_code_ok = 1'b0;
    end
    if (!seen) begin
      o_tmo = 1'b1;
      return;
    end
    o_res = rsp_result;
    o_err = rsp_err;
    o_code_resp = alu_code;
    o_wrong_ch = (o_who == 0) ? (rsp1_valid || !rsp0_valid)
                              : (rsp0_valid || !rsp1_valid);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      if (!(o_who == 0 ? rsp0_valid : rsp1_valid) || rsp_result !== o_res ||
          rsp_err !== o_err || req0_ready || req1_ready)
        o_ok_hold = 1'b0;
    end
    if (o_who == 0) rsp0_ready = 1'b1;
    else rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    o_dropped = !rsp0_valid && !rsp1_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL rst_req_ready got=%b%b exp=00", req0_ready, req1_ready);
    end
    total++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rsp_valid got=%b%b exp=00", rsp0_valid, rsp1_valid);
    end
    total++;
    if (rsp_result !== '0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_result, rsp_err);
    end
    total++;
    if (alu_op1 !== '0 || alu_op2 !== '0 || alu_code !== 3'h0) begin
      bad++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_op1, alu_op2, alu_code);
    end
    do_reset();
  endtask

  task automatic test_single_add();
    do_reset();
    set_req(0, 32'h40, 32'h02, 3'h1);
    observe(0);
    total++;
    if (o_tmo || o_who !== 0) begin
      bad++; $display("FAIL single_who got=%0d tmo=%0d exp=0", o_who, o_tmo);
    end
    total++;
    if (o_res !== 32'h42 || o_err !== 1'b0) begin
      bad++; $display("FAIL single_res got=%h/%b exp=42/0", o_res, o_err);
    end
    total++;
    if (o_code_iss !== 3'h1 || !o_code_ok || o_code_resp !== 3'h0) begin
      bad++; $display("FAIL single_code got=%h ok=%0d resp=%h exp=1/1/0",
                      o_code_iss, o_code_ok, o_code_resp);
    end
    total++;
    if (o_wrong_ch || !o_dropped || o_lat < 3) begin
      bad++; $display("FAIL single_hs got wrong=%0d drop=%0d lat=%0d exp=0/1/>=3",
                      o_wrong_ch, o_dropped, o_lat);
    end
    pref = 1 - o_who;
  endtask

  task automatic test_tie();
    int e;
    do_reset();
    set_req(0, 32'h0, 32'h0, 3'h1);
    set_req(1, 32'h40, 32'h02, 3'h1);
    e = exp_who(1, 1);
    observe(0);
    total++;
    if (o_who !== e || o_res !== 32'h0) begin
      bad++; $display("FAIL tie1 got=%0d/%h exp=%0d/0", o_who, o_res, e);
    end
    pref = 1 - e;
    set_req(0, 32'h11, 32'h22, 3'h1);
    e = exp_who(1, 1);
    observe(0);
    total++;
    if (o_who !== e || o_res !== 32'h42) begin
      bad++; $display("FAIL tie2 got=%0d/%h exp=%0d/42", o_who, o_res, e);
    end
    pref = 1 - e;
    e = exp_who(1, 0);
    observe(0);
    total++;
    if (o_who !== e || o_res !== 32'h33) begin
      bad++; $display("FAIL tie3 got=%0d/%h exp=%0d/33", o_who, o_res, e);
    end
    pref = 1 - e;
  endtask

  task automatic test_hold();
    do_reset();
    set_req(0, 32'h100, 32'h23, 3'h1);
    set_req(1, 32'h7, 32'h8, 3'h1);
    observe(3);
    total++;
    if (o_who !== 0 || o_res !== 32'h123 || !o_ok_hold || !o_dropped) begin
      bad++; $display("FAIL hold got=%0d/%h hold=%0d drop=%0d exp=0/123/1/1",
                      o_who, o_res, o_ok_hold, o_dropped);
    end
    observe(0);
    total++;
    if (o_who !== 1 || o_res !== 32'hF) begin
      bad++; $display("FAIL hold_next got=%0d/%h exp=1/f", o_who, o_res);
    end
    pref = 0;
  endtask

  task automatic test_timeout();
    int nrsp;
    bit seen;
    do_reset();
    alu_mode = 1;
    set_req(0, 32'h40, 32'h02, 3'h1);
`ifdef ALU_ARB_TIMEOUT_EN
    observe(0);
    total++;
    if (o_tmo || o_err !== 1'b1 || o_res !== '0 || o_lat != TMO + 2) begin
      bad++; $display("FAIL tmo_err got=%b/%h lat=%0d exp=1/0/%0d",
                      o_err, o_res, o_lat, TMO + 2);
    end
    alu_mode = 3;
    set_req(0, 32'h40, 32'h02, 3'h1);
    observe(0);
    total++;
    if (o_tmo || o_err !== 1'b0 || o_res !== 32'h42 || o_lat != TMO + 2) begin
      bad++; $display("FAIL tmo_edge got=%b/%h lat=%0d exp=0/42/%0d",
                      o_err, o_res, o_lat, TMO + 2);
    end
`else
    wait_accept(o_who, o_tmo);
    nrsp = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid) nrsp++;
    end
    total++;
    if (o_tmo || nrsp != 0 || alu_code !== 3'h1) begin
      bad++; $display("FAIL tmo_stuck got rsp=%0d code=%h exp=0/1", nrsp, alu_code);
    end
    alu_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || rsp_result !== 32'h42 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL tmo_recover got=%0d/%h/%b exp=1/42/0",
                      seen, rsp_result, rsp_err);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp0_ready = 1'b0;
`endif
    alu_mode = 0;
    pref = 1;
  endtask

  task automatic test_reset_mid();
    int nrsp;
    do_reset();
    alu_mode = 1;
    set_req(0, 32'h5, 32'h6, 3'h1);
    wait_accept(o_who, o_tmo);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (o_tmo || alu_code !== 3'h1) begin
      bad++; $display("FAIL mid_wait got code=%h tmo=%0d exp=1/0", alu_code, o_tmo);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (alu_code !== 3'h0 || alu_op1 !== '0 || alu_op2 !== '0 ||
        rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_result !== '0) begin
      bad++; $display("FAIL mid_rst got=%h/%h/%h rsp=%b%b res=%h exp=0",
                      alu_code, alu_op1, alu_op2, rsp0_valid, rsp1_valid, rsp_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    alu_mode = 0;
    pref = 0;
    nrsp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid) nrsp++;
    end
    total++;
    if (nrsp != 0) begin
      bad++; $display("FAIL mid_norsp got=%0d exp=0", nrsp);
    end
    set_req(0, 32'h40, 32'h02, 3'h1);
    set_req(1, 32'h1, 32'h1, 3'h1);
    observe(0);
    total++;
    if (o_who !== exp_who(1, 1) || o_res !== 32'h42) begin
      bad++; $display("FAIL mid_after got=%0d/%h exp=%0d/42", o_who, o_res, exp_who(1, 1));
    end
    pref = 1;
    observe(0);
    total++;
    if (o_who !== 1 || o_res !== 32'h2) begin
      bad++; $display("FAIL mid_after2 got=%0d/%h exp=1/2", o_who, o_res);
    end
    pref = 0;
  endtask

  task automatic test_stale_ready();
    logic [W-1:0] a, b;
    alu_mode = 2;
    a = $urandom;
    b = $urandom;
    set_req(1, a, b, 3'h1);
    observe(0);
    total++;
    if (o_who !== 1 || o_res !== a + b || o_lat != 3) begin
      bad++; $display("FAIL stale got=%0d/%h lat=%0d exp=1/%h/3", o_who, o_res, o_lat, a + b);
    end
    pref = 0;
    set_req(0, a, b, 3'h0);
    observe(0);
    total++;
    if (o_who !== 0 || o_res !== STALE || o_code_iss !== 3'h0 || o_lat != 3) begin
      bad++; $display("FAIL code0 got=%0d/%h code=%h lat=%0d exp=0/%h/0/3",
                      o_who, o_res, o_code_iss, o_lat, STALE);
    end
    pref = 1;
    alu_mode = 0;
  endtask

  task automatic test_random();
    bit           pend [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];
    logic [2:0]   pc [2];
    int           e;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    alu_mode = 0;
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) != 0) begin
          pa[n] = $urandom;
          pb[n] = $urandom;
          pc[n] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'h1;
          pend[n] = 1'b1;
          set_req(n, pa[n], pb[n], pc[n]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pa[0] = $urandom; pb[0] = $urandom; pc[0] = 3'h1;
        pend[0] = 1'b1;
        set_req(0, pa[0], pb[0], pc[0]);
      end
      e = exp_who(pend[0], pend[1]);
      observe($urandom_range(0, 2));
      total++;
      if (o_tmo || o_who !== e) begin
        bad++; $display("FAIL rnd_who it=%0d got=%0d exp=%0d", it, o_who, e);
      end
      total++;
      if (o_res !== exp_res(pa[e], pb[e], pc[e]) || o_err !== 1'b0) begin
        bad++; $display("FAIL rnd_res it=%0d got=%h/%b exp=%h/0",
                        it, o_res, o_err, exp_res(pa[e], pb[e], pc[e]));
      end
      total++;
      if (!o_ok_hold || o_wrong_ch || !o_dropped || o_lat < 3 || o_lat > 6 ||
          o_code_iss !== pc[e] || !o_code_ok) begin
        bad++; $display("FAIL rnd_hs it=%0d got hold=%0d wr=%0d dr=%0d lat=%0d code=%h",
                        it, o_ok_hold, o_wrong_ch, o_dropped, o_lat, o_code_iss);
      end
      pend[e] = 1'b0;
      pref = 1 - e;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    age = 0;
    alu_lat = 0;
    alu_mode = 0;
    pref = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_code = 3'h0;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_code = 3'h0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    alu_ready = 1'b0;
    alu_result = '0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_tie();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_stale_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
